// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the CPU MEM-stage, DMA port and memory-controller
//               signals of the data-memory arbiter. The master modport is
//               the arbiter's view; the slave modport is the surrounding
//               system (CPU, DMA engine and memory controller).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU MEM stage
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // DMA / peripheral port
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  // Memory controller
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-port data memory between the CPU MEM stage
//               and a DMA port. One access issues per cycle from IDLE, at
//               most one read is outstanding, and the CPU is stalled while
//               it waits for read data or for the DMA to release memory.
//               Optional macro MEM_ARB_RR_EN selects round-robin arbitration;
//               without it the CPU has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  mem_arbiter_if.master  bus
);

  localparam int              LAT_W     = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] C_RD_LAT  = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] C_LAT_ONE = LAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CPU_RD = 2'd1,
    S_DMA_RD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

  logic              cpu_req;
  logic              cpu_is_rd;
  logic              cpu_win;
  logic              dma_win;
  logic              cpu_done;

  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef MEM_ARB_RR_EN
  logic last_dma_q, last_dma_d;
`endif

  // Arbitration between the two requesters (only acted on in IDLE);
  // a simultaneous read+write from the CPU counts as a write.
  always_comb begin
    cpu_req   = bus.cpu_rd | bus.cpu_wr;
    cpu_is_rd = bus.cpu_rd & ~bus.cpu_wr;
`ifdef MEM_ARB_RR_EN
    // On a tie the side that did not win last time gets the memory.
    cpu_win   = cpu_req & (~bus.dma_req | last_dma_q);
`else
    cpu_win   = cpu_req;
`endif
    dma_win   = bus.dma_req & ~cpu_win;
  end

  // Next state, latency counter and all memory/requester outputs.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
`ifdef MEM_ARB_RR_EN
    last_dma_d = last_dma_q;
`endif
    cpu_done   = 1'b0;
    cpu_rdata  = '0;
    dma_gnt    = 1'b0;
    dma_rvalid = 1'b0;
    dma_rdata  = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu_win) begin
          mem_en   = 1'b1;
          mem_we   = ~cpu_is_rd;
          mem_addr = bus.cpu_addr;
`ifdef MEM_ARB_RR_EN
          last_dma_d = 1'b0;
`endif
          if (cpu_is_rd) begin
            lat_cnt_d = C_RD_LAT;
            state_d   = S_CPU_RD;
          end else begin
            mem_wdata = bus.cpu_wdata;
            cpu_done  = 1'b1;
          end
        end else if (dma_win) begin
          mem_en   = 1'b1;
          mem_we   = bus.dma_we;
          mem_addr = bus.dma_addr;
          dma_gnt  = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_dma_d = 1'b1;
`endif
          if (bus.dma_we) begin
            mem_wdata = bus.dma_wdata;
          end else begin
            lat_cnt_d = C_RD_LAT;
            state_d   = S_DMA_RD;
          end
        end
      end

      S_CPU_RD: begin
        lat_cnt_d = lat_cnt_q - C_LAT_ONE;
        if (lat_cnt_q == C_LAT_ONE) begin
          cpu_rdata = bus.mem_rdata;
          cpu_done  = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_DMA_RD: begin
        lat_cnt_d = lat_cnt_q - C_LAT_ONE;
        if (lat_cnt_q == C_LAT_ONE) begin
          dma_rdata  = bus.mem_rdata;
          dma_rvalid = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        lat_cnt_d = '0;
      end
    endcase

    cpu_stall = cpu_req & ~cpu_done;
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  always_comb begin
    bus.cpu_rdata  = rst_n ? cpu_rdata  : '0;
    bus.cpu_stall  = rst_n ? cpu_stall  : 1'b0;
    bus.dma_gnt    = rst_n ? dma_gnt    : 1'b0;
    bus.dma_rvalid = rst_n ? dma_rvalid : 1'b0;
    bus.dma_rdata  = rst_n ? dma_rdata  : '0;
    bus.mem_en     = rst_n ? mem_en     : 1'b0;
    bus.mem_we     = rst_n ? mem_we     : 1'b0;
    bus.mem_addr   = rst_n ? mem_addr   : '0;
    bus.mem_wdata  = rst_n ? mem_wdata  : '0;
  end

  // FSM state and read-latency counter; reset drops any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remembers whether the DMA won the most recent arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dma_q <= 1'b0;
    end else begin
      last_dma_q <= last_dma_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scoreboard bench for mem_arbiter with RD_LAT=2.
//               Stimulus pushes expected memory issues and read data into
//               queues; a negedge monitor pops and compares them whenever
//               the arbiter issues an access or completes a read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endfunction

  // ---------------- memory controller model ----------------
  // Unwritten words read back as their low address byte replicated.
  logic [31:0] mem     [256];
  bit          written [256] = '{default: 1'b0};
  bit          pipe_v  [RD_LAT] = '{default: 1'b0};
  logic [7:0]  pipe_a  [RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]]     <= bus.mem_wdata;
      written[bus.mem_addr[7:0]] <= 1'b1;
    end
    pipe_v[0] <= bus.mem_en && !bus.mem_we;
    pipe_a[0] <= bus.mem_addr[7:0];
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_a[k] <= pipe_a[k-1];
    end
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (pipe_v[RD_LAT-1]) begin
      if (written[pipe_a[RD_LAT-1]]) bus.mem_rdata = mem[pipe_a[RD_LAT-1]];
      else                           bus.mem_rdata = {4{pipe_a[RD_LAT-1]}};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  iss_t        exp_iss[$];
  logic [31:0] exp_cpu_rd[$];
  logic [31:0] exp_dma_rd[$];

  bit rd_busy = 1'b0;
  bit rd_dma  = 1'b0;
  int rd_done = 0;

  always @(negedge clk) begin
    iss_t e;
    bit   completing;
    if (!rst_n) begin
      rd_busy = 1'b0;
    end else begin
      completing = rd_busy && (cyc == rd_done);
      if (bus.dma_rvalid || (completing && rd_dma))
        chk("dma_rvalid_timing", bus.dma_rvalid, completing && rd_dma);
      if (completing) begin
        rd_busy = 1'b0;
        chk("completion_mem_en", bus.mem_en, 0);
        if (rd_dma) begin
          if (exp_dma_rd.size() == 0) fail("dma_rd_unexpected");
          else chk("dma_rdata", bus.dma_rdata, exp_dma_rd.pop_front());
        end else begin
          chk("cpu_done_stall", bus.cpu_stall, 0);
          if (exp_cpu_rd.size() == 0) fail("cpu_rd_unexpected");
          else chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd.pop_front());
        end
      end else if (rd_busy) begin
        chk("wait_mem_en", bus.mem_en, 0);
      end else if (bus.mem_en) begin
        if (exp_iss.size() == 0) begin
          fail("issue_unexpected");
        end else begin
          e = exp_iss.pop_front();
          chk("issue_dma_gnt", bus.dma_gnt, e.dma);
          chk("issue_mem_we", bus.mem_we, e.we);
          chk("issue_mem_addr", bus.mem_addr, e.addr);
          if (e.we) chk("issue_mem_wdata", bus.mem_wdata, e.wdata);
          if (!e.dma) chk("issue_cpu_stall", bus.cpu_stall, !e.we);
          if (!e.we) begin
            rd_busy = 1'b1;
            rd_dma  = e.dma;
            rd_done = cyc + RD_LAT;
          end
        end
      end
      if (!bus.mem_en)
        chk("idle_port_zero", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void push_iss(bit dma, bit we, logic [31:0] a, logic [31:0] d);
    iss_t e;
    e.dma = dma; e.we = we; e.addr = a; e.wdata = d;
    exp_iss.push_back(e);
  endfunction

  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output int stalls);
    bit done = 1'b0;
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    stalls = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall) done = 1'b1;
      else stalls++;
    end
    if (!done) fail("cpu_timeout");
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic dma_op(input bit we, input logic [31:0] a,
                        input logic [31:0] d, output int gnt_cyc);
    bit done = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    gnt_cyc = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.dma_gnt) begin
        done    = 1'b1;
        gnt_cyc = cyc;
      end
    end
    if (!done) fail("dma_timeout");
    @(posedge clk); #1;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  function automatic logic [175:0] all_outputs();
    return {bus.cpu_rdata, bus.cpu_stall, bus.dma_gnt, bus.dma_rvalid,
            bus.dma_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int st, g, s, rv;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b1; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h99;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h48; bus.dma_wdata = 32'h0;

    // Reset: every output zero even with requests present.
    @(negedge clk);
    chk("reset_outputs", all_outputs() == '0, 1);
    chk("reset_cpu_stall", bus.cpu_stall, 0);
    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_addr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU write then read-back.
    push_iss(0, 1, 32'h10, 32'hDEADBEEF);
    cpu_op(0, 1, 32'h10, 32'hDEADBEEF, st);
    chk("cpu_wr_stalls", st, 0);
    push_iss(0, 0, 32'h10, 32'h0);
    exp_cpu_rd.push_back(32'hDEADBEEF);
    cpu_op(1, 0, 32'h10, 32'h0, st);
    chk("cpu_rd_stalls", st, RD_LAT);

`ifndef MEM_ARB_RR_EN
    // Simultaneous reads: CPU first, DMA granted the cycle after completion.
    push_iss(0, 0, 32'h20, 32'h0);
    push_iss(1, 0, 32'h30, 32'h0);
    exp_cpu_rd.push_back(32'h20202020);
    exp_dma_rd.push_back(32'h30303030);
    s = cyc;
    fork
      cpu_op(1, 0, 32'h20, 32'h0, st);
      dma_op(0, 32'h30, 32'h0, g);
    join
    chk("tie_cpu_stalls", st, RD_LAT);
    chk("tie_dma_gnt_cycle", g - s, RD_LAT + 1);
    repeat (RD_LAT + 1) @(posedge clk);
    #1;
`endif

    // DMA read blocks a CPU write raised during its wait.
    push_iss(1, 0, 32'h40, 32'h0);
    exp_dma_rd.push_back(32'h40404040);
    push_iss(0, 1, 32'h50, 32'h55);
    dma_op(0, 32'h40, 32'h0, g);
    cpu_op(0, 1, 32'h50, 32'h55, st);
    chk("dma_block_stalls", st, RD_LAT);

    // Read and write together count as a write.
    push_iss(0, 1, 32'h8, 32'h5);
    cpu_op(1, 1, 32'h8, 32'h5, st);
    chk("rdwr_stalls", st, 0);
    push_iss(0, 0, 32'h8, 32'h0);
    exp_cpu_rd.push_back(32'h5);
    cpu_op(1, 0, 32'h8, 32'h0, st);
    chk("rdwr_readback_stalls", st, RD_LAT);

    // Reset in the cycle after a DMA read grant discards the read.
    push_iss(1, 0, 32'h40, 32'h0);
    dma_op(0, 32'h40, 32'h0, g);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midread_reset_outputs", all_outputs() == '0, 1);
    @(negedge clk);
    chk("midread_reset_outputs2", all_outputs() == '0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = 0;
    repeat (RD_LAT + 2) begin
      @(negedge clk);
      if (bus.dma_rvalid) rv++;
    end
    chk("midread_no_rvalid", rv, 0);
    @(posedge clk); #1;
    push_iss(0, 0, 32'h10, 32'h0);
    exp_cpu_rd.push_back(32'hDEADBEEF);
    cpu_op(1, 0, 32'h10, 32'h0, st);
    chk("post_reset_rd_stalls", st, RD_LAT);

`ifdef MEM_ARB_RR_EN
    // Round-robin: a DMA win first so the next tie goes to the CPU.
    push_iss(1, 1, 32'h60, 32'h66);
    dma_op(1, 32'h60, 32'h66, g);
    for (int i = 0; i < 3; i++) begin
      push_iss(0, 1, 32'h70 + 4 * i, 32'hC0 + i);
      push_iss(1, 1, 32'h80 + 4 * i, 32'hD0 + i);
    end
    s = cyc;
    fork
      begin
        for (int i = 0; i < 3; i++) cpu_op(0, 1, 32'h70 + 4 * i, 32'hC0 + i, st);
      end
      begin
        int gg;
        for (int j = 0; j < 3; j++) dma_op(1, 32'h80 + 4 * j, 32'hD0 + j, gg);
      end
    join
    chk("rr_no_idle_cycles", cyc - s, 6);
`endif

    repeat (RD_LAT + 2) @(posedge clk);
    @(negedge clk);
    chk("iss_queue_empty", exp_iss.size(), 0);
    chk("cpu_rd_queue_empty", exp_cpu_rd.size(), 0);
    chk("dma_rd_queue_empty", exp_dma_rd.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single-port data memory between two requesters: the CPU MEM stage (read/write, stalls the pipeline) and a DMA/peripheral port (request/grant handshake). It sits between the MEM stage and the memory controller. It issues at most one access per cycle and keeps at most one read outstanding. It stalls the CPU for the duration of each CPU read and while the DMA port holds the memory.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.
- `RD_LAT`, default 1, memory read latency in cycles (legal 1..3).

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_rd`  in  1  MEM-stage read request, held until `cpu_stall` is low.
- `cpu_wr`  in  1  MEM-stage write request, held until `cpu_stall` is low.
- `cpu_addr`  in  ADDR_W  CPU access address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  CPU read data, valid in the completion cycle only.
- `cpu_stall`  out  1  freeze the pipeline.
- `dma_req`  in  1  DMA request, held with `dma_*` stable until `dma_gnt`.
- `dma_we`  in  1  DMA write (1) or read (0).
- `dma_addr`  in  ADDR_W  DMA address.
- `dma_wdata`  in  DATA_W  DMA write data.
- `dma_gnt`  out  1  one-cycle pulse: request issued to memory.
- `dma_rvalid`  out  1  one-cycle pulse: `dma_rdata` valid.
- `dma_rdata`  out  DATA_W  DMA read data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid RD_LAT cycles after the issue cycle.

## Operation
- FSM states: IDLE, CPU_RD, DMA_RD. The down-counter `lat_cnt` is width ceil(log2(RD_LAT+1)).
- **IDLE, arbitration:**
  - The winner is selected from `cpu_rd|cpu_wr` and `dma_req`.
  - The winner drives `mem_en=1`, `mem_we`, `mem_addr` and `mem_wdata` combinationally in the same cycle (the issue cycle).
- **Write issue:**
  - Completes in the issue cycle. The FSM stays in IDLE.
  - CPU write: `cpu_stall=0` in that cycle.
  - DMA write: `dma_gnt=1`.
- **Read issue:**
  - Loads `lat_cnt=RD_LAT` and moves to CPU_RD or DMA_RD.
  - CPU read: `cpu_stall=1` in the issue cycle.
  - DMA read: `dma_gnt=1` in the issue cycle.
- **CPU_RD / DMA_RD:**
  - `lat_cnt` decrements each cycle and `mem_en=0`.
  - When `lat_cnt==1` (the completion cycle): `cpu_rdata=mem_rdata` with `cpu_stall=0`, or `dma_rdata=mem_rdata` with `dma_rvalid=1`. The FSM then returns to IDLE.
- **`cpu_stall`:**
  - Equals `(cpu_rd|cpu_wr)` AND NOT (CPU access completing this cycle).
  - So it is high while the DMA wins, while a DMA read is outstanding, and during a CPU read's wait cycles.
- `cpu_rdata` and `dma_rdata` are 0 outside their completion cycles.
- `cpu_rd` and `cpu_wr` both high: treated as a write (no read performed).
- Arbitration without the configuration macro: fixed CPU priority.
- Idle memory port: `mem_addr` and `mem_wdata` are 0 whenever `mem_en=0`.

## Timing
- While `rst_n=0`:
  - State=IDLE, `lat_cnt=0`.
  - Every output is 0, including `cpu_stall`, `dma_gnt`, `dma_rvalid` and `mem_en`.
- Reset during CPU_RD or DMA_RD: the outstanding read is discarded, with no `dma_rvalid` and no CPU completion.
- Latencies:
  - CPU write: 0 stall cycles.
  - CPU read: RD_LAT stall cycles, data in cycle issue+RD_LAT.
  - DMA read: `dma_rvalid` RD_LAT cycles after `dma_gnt`.
- Throughput:
  - Writes: one per cycle.
  - Reads: one per RD_LAT+1 cycles. A read completion cycle never issues a new access; it is followed by IDLE.
- DMA handshake: `dma_req` may drop only in the cycle after `dma_gnt`. Dropping it earlier is a protocol violation; the arbiter does not need to handle it.
- Requests arriving in CPU_RD or DMA_RD wait for IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_dma` register, reset 0, is set when the DMA wins and cleared when the CPU wins.
  - On a tie, the requester that did not win last gets the grant.
- Undefined: fixed CPU priority; `last_dma` is not implemented. A continuously requesting CPU may starve the DMA, by design.

## Test plan
- **Reset mid-read:** RD_LAT=2, DMA read `dma_addr=0x40`, `rst_n` low one cycle after `dma_gnt` -> no `dma_rvalid`, all outputs 0, IDLE after release.
- **CPU write/read round trip:**
  - CPU write `0x10 <- 0xDEADBEEF` -> `mem_en=1`, `mem_we=1` in the same cycle, `cpu_stall=0`.
  - Then CPU read `0x10` with RD_LAT=1 -> `cpu_stall=1` for one cycle, then `cpu_rdata=0xDEADBEEF` with `cpu_stall=0`.
- **Simultaneous requests without the macro:** CPU read `0x20` and DMA read `0x30` together -> CPU issued first; DMA granted in the cycle after the CPU completion. `dma_rvalid` comes RD_LAT cycles later with the memory word at `0x30`.
- **Simultaneous requests with `MEM_ARB_RR_EN`:** three back-to-back CPU writes and DMA writes held together -> grant order CPU, DMA, CPU, DMA, CPU, DMA with zero idle cycles.
- **DMA blocking CPU:** `cpu_wr` raised in the DMA_RD wait (RD_LAT=3) -> `cpu_stall=1` until the IDLE cycle in which the write issues.
- **Both `cpu_rd` and `cpu_wr` high:** `addr=0x8`, `wdata=0x5` -> `mem_we=1`, no read wait, and a subsequent read of `0x8` returns `0x5`.
